// File: rtl/accel_intr_ctrl.sv
// -----------------------------------------------------------------------------
// accel_intr_ctrl
// Interrupt controller for accelerator channels. It latches raw interrupts into
// a PENDING register, in edge or level mode per channel. Software clears PENDING
// bits with write-1-to-clear. A per-channel enable masks the interrupt vector.
// A coalescing FSM turns FAST_SEL channels into one fast interrupt. The fast
// interrupt fires on an event-count threshold or on a cycle timeout.
//
// Ports:
//   clk_i          clock, all state on rising edge
//   rst_i          asynchronous active-high reset
//   intr_i         raw interrupt lines, NUM_CH wide
//   req_valid_i    register access strobe
//   req_write_i    1 = write, 0 = read
//   req_addr_i     byte address (word aligned)
//   req_wdata_i    write data
//   rsp_rdata_o    read data, same cycle as the request
//   rsp_error_o    misaligned access flag, same cycle as the request
//   intr_vector_o  PENDING & ENABLE
//   fast_intr_o    coalesced fast interrupt, high while the FSM is in FIRE
// -----------------------------------------------------------------------------
module accel_intr_ctrl #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] intr_i,
    input  logic              req_valid_i,
    input  logic              req_write_i,
    input  logic [4:0]        req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_error_o,
    output logic [NUM_CH-1:0] intr_vector_o,
    output logic              fast_intr_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_FIRE  = 2'd2
    } coal_state_e;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] fast_sel_q, fast_sel_d;
    logic [NUM_CH-1:0] hist_q;
    logic [CNT_W-1:0]  thr_q, thr_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  evt_cnt_q, tmo_cnt_q;
    coal_state_e       state_q;
    logic              fast_q;

    logic              aligned_s;
    logic              wr_s;
    logic              ack_s;
    logic [NUM_CH-1:0] clr_s;
    logic [NUM_CH-1:0] set_s;
    logic              evt_s;
    logic [CNT_W-1:0]  evt_nxt_s;
    logic [CNT_W-1:0]  tmo_nxt_s;
    logic              fire_s;

    assign aligned_s = (req_addr_i[1:0] == 2'b00);
    assign wr_s      = req_valid_i & req_write_i & aligned_s;

    // Edge channels set on a 0->1 against the history register; level channels set whenever high.
    assign set_s = (mode_q & intr_i & ~hist_q) | (~mode_q & intr_i);

    // An event is any enabled fast channel going 0->1 in PENDING; several at once count as one.
    assign evt_s = |(set_s & ~pending_q & enable_q & fast_sel_q);

    assign intr_vector_o = pending_q & enable_q;
    assign fast_intr_o   = fast_q;

    // Register write decode and next-state values of the software-visible registers.
    always_comb begin
        enable_d   = enable_q;
        mode_d     = mode_q;
        fast_sel_d = fast_sel_q;
        thr_d      = thr_q;
        tmo_d      = tmo_q;
        clr_s      = {NUM_CH{1'b0}};
        ack_s      = 1'b0;
        if (wr_s) begin
            case (req_addr_i[4:2])
                3'd0:    enable_d   = req_wdata_i[NUM_CH-1:0];
                3'd1:    clr_s      = req_wdata_i[NUM_CH-1:0];
                3'd2:    mode_d     = req_wdata_i[NUM_CH-1:0];
                3'd3:    fast_sel_d = req_wdata_i[NUM_CH-1:0];
                3'd5:    thr_d      = req_wdata_i[CNT_W-1:0];
                3'd6:    tmo_d      = req_wdata_i[CNT_W-1:0];
                3'd7:    ack_s      = 1'b1;
                default: ack_s      = 1'b0;  // RAW is read-only; writes are ignored
            endcase
        end else begin
            ack_s = 1'b0;
        end
        // A set in the same cycle wins over a W1C clear.
        pending_d = (pending_q & ~clr_s) | set_s;
    end

    // Combinational read mux; it returns pre-edge register values.
    always_comb begin
        rsp_rdata_o = 32'h0000_0000;
        rsp_error_o = 1'b0;
        if (req_valid_i && !aligned_s) begin
            rsp_error_o = 1'b1;
        end else if (req_valid_i && !req_write_i) begin
            case (req_addr_i[4:2])
                3'd0:    rsp_rdata_o = 32'(enable_q);
                3'd1:    rsp_rdata_o = 32'(pending_q);
                3'd2:    rsp_rdata_o = 32'(mode_q);
                3'd3:    rsp_rdata_o = 32'(fast_sel_q);
                3'd4:    rsp_rdata_o = 32'(intr_i);
                3'd5:    rsp_rdata_o = 32'(thr_q);
                3'd6:    rsp_rdata_o = 32'(tmo_q);
                default: rsp_rdata_o = 32'h0000_0000;  // COAL_ACK is write-only
            endcase
        end else begin
            rsp_rdata_o = 32'h0000_0000;
        end
    end

    // Counter values after this cycle while in ACCUM, and the FIRE decision based on them.
    always_comb begin
        if (evt_s && (evt_cnt_q != CNT_MAX)) begin
            evt_nxt_s = evt_cnt_q + CNT_ONE;
        end else begin
            evt_nxt_s = evt_cnt_q;
        end
        tmo_nxt_s = tmo_cnt_q + CNT_ONE;
        fire_s    = (evt_nxt_s >= thr_q) || ((tmo_q != CNT_ZERO) && (tmo_nxt_s == tmo_q));
    end

    // Software registers, PENDING and the interrupt history.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            enable_q   <= {NUM_CH{1'b0}};
            pending_q  <= {NUM_CH{1'b0}};
            mode_q     <= {NUM_CH{1'b0}};
            fast_sel_q <= {NUM_CH{1'b0}};
            hist_q     <= {NUM_CH{1'b0}};
            thr_q      <= CNT_ZERO;
            tmo_q      <= CNT_ZERO;
        end else begin
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            mode_q     <= mode_d;
            fast_sel_q <= fast_sel_d;
            hist_q     <= intr_i;
            thr_q      <= thr_d;
            tmo_q      <= tmo_d;
        end
    end

    // Coalescing FSM with its counters and the registered fast interrupt.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            evt_cnt_q <= CNT_ZERO;
            tmo_cnt_q <= CNT_ZERO;
            fast_q    <= 1'b0;
        end else if (ack_s) begin
            // An ACK returns to IDLE, and it drops any event in the same cycle.
            state_q   <= ST_IDLE;
            evt_cnt_q <= CNT_ZERO;
            tmo_cnt_q <= CNT_ZERO;
            fast_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (evt_s) begin
                        evt_cnt_q <= CNT_ONE;
                        tmo_cnt_q <= CNT_ZERO;
                        if (thr_q <= CNT_ONE) begin
                            state_q <= ST_FIRE;
                            fast_q  <= 1'b1;
                        end else begin
                            state_q <= ST_ACCUM;
                            fast_q  <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        fast_q  <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    evt_cnt_q <= evt_nxt_s;
                    tmo_cnt_q <= tmo_nxt_s;
                    if (fire_s) begin
                        state_q <= ST_FIRE;
                        fast_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ACCUM;
                        fast_q  <= 1'b0;
                    end
                end
                ST_FIRE: begin
                    state_q <= ST_FIRE;
                    fast_q  <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    evt_cnt_q <= CNT_ZERO;
                    tmo_cnt_q <= CNT_ZERO;
                    fast_q    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_intr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_accel_intr_ctrl
// Directed self-checking bench for accel_intr_ctrl using the default parameters
// (NUM_CH=4, CNT_W=8). Inputs change 1 time unit after a rising edge. Outputs
// are sampled before the next edge.
// -----------------------------------------------------------------------------
module tb_accel_intr_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  intr_i;
    logic        req_valid_i;
    logic        req_write_i;
    logic [4:0]  req_addr_i;
    logic [31:0] req_wdata_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_error_o;
    logic [3:0]  intr_vector_o;
    logic        fast_intr_o;

    int n_cmp = 0;
    int n_mis = 0;

    accel_intr_ctrl #(.NUM_CH(4), .CNT_W(8)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .intr_i        (intr_i),
        .req_valid_i   (req_valid_i),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_error_o   (rsp_error_o),
        .intr_vector_o (intr_vector_o),
        .fast_intr_o   (fast_intr_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic reg_write(input logic [4:0] addr, input logic [31:0] data);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = addr;
        req_wdata_i = data;
        tick(1);
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_wdata_i = 32'h0;
    endtask

    task automatic reg_read(input logic [4:0] addr, output logic [31:0] data, output logic err);
        req_valid_i = 1'b1;
        req_write_i = 1'b0;
        req_addr_i  = addr;
        #1;
        data = rsp_rdata_o;
        err  = rsp_error_o;
        req_valid_i = 1'b0;
        #1;
    endtask

    task automatic pulse(input int ch);
        intr_i[ch] = 1'b1;
        tick(1);
        intr_i[ch] = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;

    initial begin
        rst_i       = 1'b1;
        intr_i      = 4'h0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 5'h00;
        req_wdata_i = 32'h0;
        tick(3);
        check_val("rst_vector", {28'h0, intr_vector_o}, 32'h0);
        check_val("rst_fast", {31'h0, fast_intr_o}, 32'h0);
        check_val("idle_rdata", rsp_rdata_o, 32'h0);
        check_val("idle_error", {31'h0, rsp_error_o}, 32'h0);
        rst_i = 1'b0;
        tick(1);

        // Reserved bits read as zero.
        reg_write(5'h00, 32'hFFFF_FFFF);
        reg_read(5'h00, rd, er);
        check_val("enable_mask", rd, 32'h0000_000F);
        reg_write(5'h14, 32'h0000_01FF);
        reg_read(5'h14, rd, er);
        check_val("thr_mask", rd, 32'h0000_00FF);
        // A misaligned write has no side effect.
        reg_write(5'h01, 32'h0);
        reg_read(5'h00, rd, er);
        check_val("misaligned_wr", rd, 32'h0000_000F);

        // Edge-mode pulse on ch0, followed by a W1C clear.
        reg_write(5'h00, 32'h1);
        reg_write(5'h08, 32'h1);
        pulse(0);
        reg_read(5'h04, rd, er);
        check_val("edge_pending", rd, 32'h1);
        check_val("edge_vector", {28'h0, intr_vector_o}, 32'h1);
        reg_write(5'h04, 32'h1);
        reg_read(5'h04, rd, er);
        check_val("w1c_clear", rd, 32'h0);

        // Level mode: a held line survives W1C, then clears once released.
        reg_write(5'h08, 32'h0);
        intr_i[1] = 1'b1;
        tick(1);
        reg_read(5'h10, rd, er);
        check_val("raw_read", rd, 32'h2);
        reg_write(5'h04, 32'h2);
        reg_read(5'h04, rd, er);
        check_val("level_hold", rd, 32'h2);
        check_val("vector_masked", {28'h0, intr_vector_o}, 32'h0);
        intr_i[1] = 1'b0;
        reg_write(5'h04, 32'h2);
        reg_read(5'h04, rd, er);
        check_val("level_clear", rd, 32'h0);

        // Threshold coalescing: three edge events are needed to fire.
        reg_write(5'h00, 32'hF);
        reg_write(5'h0C, 32'hF);
        reg_write(5'h08, 32'hF);
        reg_write(5'h14, 32'h3);
        reg_write(5'h18, 32'h0);
        pulse(0);
        check_val("thr_ev1", {31'h0, fast_intr_o}, 32'h0);
        pulse(1);
        check_val("thr_ev2", {31'h0, fast_intr_o}, 32'h0);
        pulse(2);
        check_val("thr_ev3", {31'h0, fast_intr_o}, 32'h1);
        tick(3);
        check_val("fire_hold", {31'h0, fast_intr_o}, 32'h1);
        reg_write(5'h1C, 32'h0);
        check_val("ack_clear", {31'h0, fast_intr_o}, 32'h0);
        reg_read(5'h04, rd, er);
        check_val("thr_pending", rd, 32'h7);
        reg_write(5'h04, 32'hF);

        // Timeout coalescing: a single event fires 5 cycles after ACCUM entry.
        reg_write(5'h14, 32'h8);
        reg_write(5'h18, 32'h5);
        pulse(3);
        tick(4);
        check_val("tmo_early", {31'h0, fast_intr_o}, 32'h0);
        tick(1);
        check_val("tmo_fire", {31'h0, fast_intr_o}, 32'h1);
        reg_write(5'h1C, 32'h0);
        reg_write(5'h04, 32'hF);

        // A threshold of 1 fires right after the first event.
        reg_write(5'h14, 32'h1);
        pulse(0);
        check_val("thr1_fire", {31'h0, fast_intr_o}, 32'h1);
        check_val("pre_rst_vec", {28'h0, intr_vector_o}, 32'h1);

        // Asynchronous reset while in FIRE.
        rst_i = 1'b1;
        #1;
        check_val("async_fast", {31'h0, fast_intr_o}, 32'h0);
        check_val("async_vector", {28'h0, intr_vector_o}, 32'h0);
        tick(1);
        rst_i = 1'b0;
        tick(1);
        reg_read(5'h00, rd, er);
        check_val("rst_enable", rd, 32'h0);
        reg_read(5'h03, rd, er);
        check_val("misalign_err", {31'h0, er}, 32'h1);
        check_val("misalign_data", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
